textlcd_arbiter: RTL and testbench

- Shares the text-LCD parallel bus (lcd_rs/lcd_rw/lcd_en/lcd_data) between two requesters.
- Each requester hands over one byte at a time (command or data) on a req/ack handshake.
- The arbiter picks a winner round-robin, runs the HD44780-style write cycle with programmed setup, enable, hold and execution delays, then re-arbitrates.
- It sits between user logic and the LCD pins, on the lcdclk domain (25 MHz, 40 ns).

---
 rtl/textlcd_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_textlcd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/textlcd_arbiter.sv
// rtl/textlcd_arbiter.sv - two-port round-robin arbiter for an HD44780-style text-LCD write bus
// Optional power-on init sequence (38/0C/06/01) enabled by defining TEXTLCD_ARB_INIT_EN.
module textlcd_arbiter #(
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 1000,
  parameter int T_EXEC_LONG = 41000,
  parameter int CNT_W       = 16
) (
  input  logic       lcdclk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_en_q, lcd_en_d;
  logic [7:0]         lcd_data_q, lcd_data_d;

  logic               grant0, grant1, start;
  logic               is_long;

`ifdef TEXTLCD_ARB_INIT_EN
  logic [2:0]         init_idx_q, init_idx_d;
  logic               init_pending;
  logic [7:0]         init_byte;

  // Internal init commands run before any external port may be granted
  assign init_pending = (init_idx_q != 3'd4);

  // Init command table: function set, display on, entry mode, clear
  always_comb begin
    case (init_idx_q)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  assign grant0 = !init_pending && req0 && (!req1 || last_grant_q);
  assign grant1 = !init_pending && req1 && (!req0 || !last_grant_q);
  assign start  = init_pending || grant0 || grant1;
`else
  // Round-robin: on a tie the port that did not win last time is granted
  assign grant0 = req0 && (!req1 || last_grant_q);
  assign grant1 = req1 && (!req0 || !last_grant_q);
  assign start  = grant0 || grant1;
`endif

  // Clear (01) and home (02/03) commands need the long execution wait
  assign is_long = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02) ||
                                 (lcd_data_q == 8'h03));

  // State and datapath registers; reset aborts any write cycle immediately
  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
`ifdef TEXTLCD_ARB_INIT_EN
      init_idx_q   <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_en_q     <= lcd_en_d;
      lcd_data_q   <= lcd_data_d;
`ifdef TEXTLCD_ARB_INIT_EN
      init_idx_q   <= init_idx_d;
`endif
    end
  end

  // Next-state: each timed phase advances when its counter reaches zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)         state_d = S_SETUP;
      S_SETUP:  if (cnt_q == '0)   state_d = S_ENABLE;
      S_ENABLE: if (cnt_q == '0)   state_d = S_HOLD;
      S_HOLD:   if (cnt_q == '0)   state_d = S_WAIT;
      S_WAIT:   if (cnt_q == '0)   state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Delay counter: load (T-1) on every state entry, count down, park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        S_SETUP:  cnt_d = CNT_W'(T_SETUP - 1);
        S_ENABLE: cnt_d = CNT_W'(T_EN - 1);
        S_HOLD:   cnt_d = CNT_W'(T_HOLD - 1);
        S_WAIT:   cnt_d = is_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
        default:  cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs: latch the granted byte, pulse ack, derive strobe and busy from next state
  always_comb begin
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    last_grant_d = last_grant_q;
`ifdef TEXTLCD_ARB_INIT_EN
    init_idx_d   = init_idx_q;
`endif
    if (state_q == S_IDLE) begin
`ifdef TEXTLCD_ARB_INIT_EN
      if (init_pending) begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_byte;
        init_idx_d = init_idx_q + 3'd1;
      end else
`endif
      if (grant0) begin
        ack0_d       = 1'b1;
        lcd_rs_d     = rs0;
        lcd_data_d   = data0;
        last_grant_d = 1'b0;
      end else if (grant1) begin
        ack1_d       = 1'b1;
        lcd_rs_d     = rs1;
        lcd_data_d   = data1;
        last_grant_d = 1'b1;
      end
    end
    lcd_en_d = (state_d == S_ENABLE);
`ifdef TEXTLCD_ARB_INIT_EN
    busy_d   = (state_d != S_IDLE) || (init_idx_d != 3'd4);
`else
    busy_d   = (state_d != S_IDLE);
`endif
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_textlcd_arbiter.sv
// tb/tb_textlcd_arbiter.sv - scoreboard bench for textlcd_arbiter
module tb_textlcd_arbiter;

  logic       lcdclk = 1'b0;
  logic       reset  = 1'b1;
  logic       req0 = 1'b0, rs0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       ack0, ack1, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       en_prev = 1'b0;
  logic [8:0] exp_q[$];

  textlcd_arbiter dut (
    .lcdclk   (lcdclk),
    .reset    (reset),
    .req0     (req0),
    .rs0      (rs0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .rs1      (rs1),
    .data1    (data1),
    .ack1     (ack1),
    .busy     (busy),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  always #20 lcdclk = ~lcdclk;

  always @(posedge lcdclk) cyc <= cyc + 1;

  // Advance to the next falling edge; pop the scoreboard on every lcd_en rising edge
  task automatic step();
    logic [8:0] exp_v;
    @(negedge lcdclk);
    total++;
    if (lcd_rw !== 1'b0) begin
      bad++;
      $display("FAIL lcd_rw actual=%b required=0 cyc=%0d", lcd_rw, cyc);
    end
    if (lcd_en === 1'b1 && en_prev === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected actual=%h required=none cyc=%0d", {lcd_rs, lcd_data}, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        if ({lcd_rs, lcd_data} !== exp_v) begin
          bad++;
          $display("FAIL strobe_byte actual=%h required=%h cyc=%0d", {lcd_rs, lcd_data}, exp_v, cyc);
        end
      end
    end
    en_prev = lcd_en;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++;
    if ({ack0, ack1, busy, lcd_rs, lcd_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl actual=%b required=00000", {ack0, ack1, busy, lcd_rs, lcd_en});
    end
    total++;
    if (lcd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data actual=%h required=00", lcd_data);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if ({ack0, ack1, busy, lcd_en} !== 4'b0) begin
      bad++;
      $display("FAIL idle_no_req actual=%b required=0000", {ack0, ack1, busy, lcd_en});
    end
  endtask

  task automatic test_single();
    int n, rise, last, bfall, acks;
    pulse_reset();
    exp_q.push_back({1'b1, 8'h41});
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    n = cyc;
    step();
    total++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      bad++;
      $display("FAIL single_ack actual=%b%b required=10", ack0, ack1);
    end
    total++;
    if ({lcd_rs, lcd_data} !== {1'b1, 8'h41} || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latch actual=%b_%h_%b required=1_41_1", lcd_rs, lcd_data, busy);
    end
    req0 = 1'b0;
    rise = -1; last = -1; bfall = -1; acks = 0;
    for (int i = 0; i < 1030; i++) begin
      step();
      if (lcd_en === 1'b1 && rise < 0) rise = cyc - n;
      if (lcd_en === 1'b0 && rise >= 0 && last < 0) last = cyc - n - 1;
      if (busy === 1'b0 && bfall < 0) bfall = cyc - n;
      if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
      if (lcd_en === 1'b1 && {lcd_rs, lcd_data} !== {1'b1, 8'h41}) acks += 100;
    end
    total++;
    if (rise !== 3) begin bad++; $display("FAIL single_en_rise actual=%0d required=3", rise); end
    total++;
    if (last !== 14) begin bad++; $display("FAIL single_en_last actual=%0d required=14", last); end
    total++;
    if (bfall !== 1017) begin bad++; $display("FAIL single_busy_fall actual=%0d required=1017", bfall); end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL single_extra actual=%0d required=0", acks); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL single_drain actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int who[$];
    int when[$];
    int bfall;
    reset = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'hAA;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
    step();
    exp_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b1, 8'h55});
    reset = 1'b0;
    for (int i = 0; i < 4200 && who.size() < 4; i++) begin
      step();
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        total++; bad++;
        $display("FAIL rr_both_ack actual=11 required=one_hot");
      end
      if (ack0 === 1'b1) begin who.push_back(0); when.push_back(cyc); end
      if (ack1 === 1'b1) begin who.push_back(1); when.push_back(cyc); end
    end
    req0 = 1'b0; req1 = 1'b0;
    bfall = -1;
    for (int i = 0; i < 1100 && bfall < 0; i++) begin
      step();
      if (busy === 1'b0) bfall = cyc;
    end
    total++;
    if (who.size() !== 4) begin
      bad++;
      $display("FAIL rr_ack_count actual=%0d required=4", who.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (who[k] !== (k % 2)) begin
          bad++;
          $display("FAIL rr_order idx=%0d actual=%0d required=%0d", k, who[k], k % 2);
        end
      end
      total++;
      if (when[1] - when[0] !== 1017) begin
        bad++;
        $display("FAIL rr_gap actual=%0d required=1017", when[1] - when[0]);
      end
    end
    total++;
    if (bfall < 0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL rr_drain actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_long_wait();
    int a1, a2, a3, bfall;
    pulse_reset();
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h80;
    exp_q.push_back({1'b0, 8'h80});
    a1 = -1;
    for (int i = 0; i < 1100 && a1 < 0; i++) begin step(); if (ack1 === 1'b1) a1 = cyc; end
    data1 = 8'h01;
    exp_q.push_back({1'b0, 8'h01});
    a2 = -1;
    for (int i = 0; i < 1100 && a2 < 0; i++) begin step(); if (ack1 === 1'b1) a2 = cyc; end
    data1 = 8'h80;
    exp_q.push_back({1'b0, 8'h80});
    a3 = -1;
    for (int i = 0; i < 41100 && a3 < 0; i++) begin step(); if (ack1 === 1'b1) a3 = cyc; end
    req1 = 1'b0;
    bfall = -1;
    for (int i = 0; i < 1100 && bfall < 0; i++) begin step(); if (busy === 1'b0) bfall = cyc; end
    total++;
    if (a1 < 0 || a2 < 0 || a2 - a1 !== 1017) begin
      bad++;
      $display("FAIL short_gap actual=%0d required=1017", a2 - a1);
    end
    total++;
    if (a3 < 0 || a3 - a2 !== 41017) begin
      bad++;
      $display("FAIL long_gap actual=%0d required=41017", a3 - a2);
    end
    total++;
    if (bfall < 0 || bfall - a3 !== 1016) begin
      bad++;
      $display("FAIL long_tail actual=%0d required=1016", bfall - a3);
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL long_drain actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int n, ak, rise, bfall;
    pulse_reset();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h33;
    exp_q.push_back({1'b1, 8'h33});
    ak = -1;
    for (int i = 0; i < 10 && ak < 0; i++) begin step(); if (ack0 === 1'b1) ak = cyc; end
    req0 = 1'b0;
    for (int i = 0; i < 20 && lcd_en !== 1'b1; i++) step();
    for (int i = 0; i < 3; i++) step();
    total++;
    if (lcd_en !== 1'b1) begin bad++; $display("FAIL abort_pre_en actual=%b required=1", lcd_en); end
    reset = 1'b1;
    #1;
    total++;
    if ({lcd_en, busy, ack0} !== 3'b000 || lcd_data !== 8'h00) begin
      bad++;
      $display("FAIL abort_now actual=%b_%h required=000_00", {lcd_en, busy, ack0}, lcd_data);
    end
    step();
    reset = 1'b0;
    step();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h34;
    exp_q.push_back({1'b1, 8'h34});
    n = cyc;
    step();
    total++;
    if (ack0 !== 1'b1 || lcd_data !== 8'h34) begin
      bad++;
      $display("FAIL abort_regrant actual=%b_%h required=1_34", ack0, lcd_data);
    end
    req0 = 1'b0;
    rise = -1; bfall = -1;
    for (int i = 0; i < 1030; i++) begin
      step();
      if (lcd_en === 1'b1 && rise < 0) rise = cyc - n;
      if (busy === 1'b0 && bfall < 0) bfall = cyc - n;
    end
    total++;
    if (rise !== 3 || bfall !== 1017) begin
      bad++;
      $display("FAIL abort_timing actual=%0d_%0d required=3_1017", rise, bfall);
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL abort_drain actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_pulse_busy();
    int ak, acks, bfall;
    pulse_reset();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h50;
    exp_q.push_back({1'b1, 8'h50});
    ak = -1;
    for (int i = 0; i < 10 && ak < 0; i++) begin step(); if (ack0 === 1'b1) ak = cyc; end
    req0 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    req0 = 1'b1; data0 = 8'h66;
    step();
    req0 = 1'b0;
    acks = 0; bfall = -1;
    for (int i = 0; i < 1030; i++) begin
      step();
      if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
      if (busy === 1'b0 && bfall < 0) bfall = cyc;
    end
    total++;
    if (ak < 0 || acks !== 0) begin
      bad++;
      $display("FAIL pulse_acks actual=%0d required=0", acks);
    end
    total++;
    if (bfall < 0 || bfall - ak !== 1016) begin
      bad++;
      $display("FAIL pulse_busy_fall actual=%0d required=1016", bfall - ak);
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL pulse_drain actual=%0d required=0", exp_q.size()); end
  endtask

`ifdef TEXTLCD_ARB_INIT_EN
  task automatic test_init();
    int ak, lows, pend, bfall;
    reset = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    step();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h41});
    reset = 1'b0;
    ak = -1; lows = 0; pend = -1;
    for (int i = 0; i < 46000 && ak < 0; i++) begin
      step();
      if (i > 0 && busy !== 1'b1) lows++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin ak = cyc; pend = exp_q.size(); end
    end
    req0 = 1'b0;
    bfall = -1;
    for (int i = 0; i < 1100 && bfall < 0; i++) begin step(); if (busy === 1'b0) bfall = cyc; end
    total++;
    if (ak < 0 || pend !== 1 || ack1 === 1'b1) begin
      bad++;
      $display("FAIL init_first_ack actual=%0d required=1", pend);
    end
    total++;
    if (lows !== 0) begin bad++; $display("FAIL init_busy actual=%0d required=0", lows); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL init_drain actual=%0d required=0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TEXTLCD_ARB_INIT_EN
    test_init();
`else
    test_single();
    test_round_robin();
    test_long_wait();
    test_abort();
    test_pulse_busy();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
